// File: rtl/configurable_queue.sv
// Same-clock-domain queue: any depth, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and a
// selectable read mode (registered or first-word-fall-through).
module configurable_queue #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned AE_THRESH = 1,
  parameter bit          FWFT      = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq,
  input  logic                       deq,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    front_q, front_d;
  logic [PW-1:0]    rear_q,  rear_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q,   ovf_d;
  logic             udf_q,   udf_d;
  logic             deq_ok;
  logic             enq_ok;

  // Status flags decoded directly from the occupancy register
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Accept decisions; a pop frees the slot an enqueue-while-full needs
  assign deq_ok = deq && !empty && !flush;
  assign enq_ok = enq && !flush && (!full || deq_ok);

  // Next-state for pointers, occupancy and sticky error flags
  always_comb begin
    front_d = front_q;
    rear_d  = rear_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (flush) begin
      front_d = '0;
      rear_d  = '0;
      count_d = '0;
    end else begin
      if (enq && !enq_ok) ovf_d = 1'b1;
      if (deq && !deq_ok) udf_d = 1'b1;
      if (enq_ok) rear_d  = (rear_q  == PW'(DEPTH - 1)) ? '0 : rear_q  + PW'(1);
      if (deq_ok) front_d = (front_q == PW'(DEPTH - 1)) ? '0 : front_q + PW'(1);
      if (enq_ok && !deq_ok)      count_d = count_q + CW'(1);
      else if (deq_ok && !enq_ok) count_d = count_q - CW'(1);
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      front_q <= front_d;
      rear_q  <= rear_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[rear_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word visible combinationally; zero while empty
      assign data_out = empty ? '0 : mem_q[front_q];
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      // Registered read: popped word appears one cycle after the dequeue
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       dout_q <= '0;
        else if (deq_ok) dout_q <= mem_q[front_q];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule
